// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-ALU/shared-memory RV32 multi-cycle datapath.
// state_o encodes the states in declaration order: FETCH=0 ... HALT=10.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [CNT_W:0] LIMIT_W = (CNT_W+1)'(WAIT_LIMIT);

  // Moore control word for a state; only MEMADR looks at the (stable) IR opcode.
  function automatic ctl_t ctl_of(input state_t s, input logic [6:0] op);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 2'b10;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = (op == OP_STORE) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b01;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB:  c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_err;
  ctl_t             r_ctl;

  state_t           w_next;
  logic [1:0]       w_err_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_taken;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                       (r_state == S_MEMWRITE);
  assign w_cnt_inc   = {1'b0, r_cnt} + (CNT_W+1)'(1);
  // Timeout fires on the wait cycle that would bring the count to the limit.
  assign w_timeout   = (WAIT_LIMIT != 0) && w_mem_state && !mem_ready &&
                       (w_cnt_inc >= LIMIT_W);
  assign w_taken     = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_comb begin
    w_next     = r_state;
    w_err_next = r_err;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next     = S_HALT;
          w_err_next = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BR:             w_next = S_BRANCH;
          default: begin
            w_next     = S_HALT;
            w_err_next = 2'b01;
          end
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_next     = S_HALT;
          w_err_next = 2'b10;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next     = S_HALT;
          w_err_next = 2'b10;
        end
      end
      S_EXEC_R, S_EXEC_I:          w_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH:  w_next = S_FETCH;
      S_HALT:                      w_next = S_HALT;
      default:                     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_next != r_state) begin
      w_cnt_next = '0;
    end else if (w_mem_state && !mem_ready && (r_cnt != '1)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Control word is registered from the next state; reset loads FETCH's word
  // so the first post-reset cycle already drives a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_err   <= 2'b00;
      r_ctl   <= ctl_of(S_FETCH, 7'd0);
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_ctl   <= ctl_of(w_next, opcode);
    end
  end

  assign mem_req    = rst_n & r_ctl.mem_req;
  assign mem_we     = rst_n & r_ctl.mem_we;
  assign adr_src    = rst_n & r_ctl.adr_src;
  assign reg_write  = rst_n & r_ctl.reg_write;
  assign imm_src    = {2{rst_n}} & r_ctl.imm_src;
  assign alu_src_a  = {2{rst_n}} & r_ctl.alu_src_a;
  assign alu_src_b  = {2{rst_n}} & r_ctl.alu_src_b;
  assign alu_op     = {2{rst_n}} & r_ctl.alu_op;
  assign result_src = {2{rst_n}} & r_ctl.result_src;
  assign ir_write   = rst_n & (r_state == S_FETCH) & mem_ready;
  assign pc_write   = rst_n & (((r_state == S_FETCH) & mem_ready) |
                               ((r_state == S_BRANCH) & w_taken));
  assign err        = r_err;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: random instruction/wait-state stimulus against a
// route-queue model of the instruction phases.
module tb_multicycle_ctrl;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src, err;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .err(err), .state_o(state_o)
  );

  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXEC_R, P_EXEC_I, P_ALUWB, P_BRANCH, P_HALT} phase_e;
  typedef logic [21:0] vec_t;

  vec_t w_act;
  assign w_act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, imm_src,
                  alu_src_a, alu_src_b, alu_op, result_src, err, state_o};

  vec_t   sb[$];
  int     n_vec = 0;
  int     n_bad = 0;
  phase_e ph;
  phase_e route[$];
  int     waited;
  logic [1:0] m_err;
  int     ready_pct;
  int     halt_cnt = 0;
  int     wr_resets = 0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b required %b (mreq,mwe,adr,irw,pcw,rw,imm,a,b,op,res,err,st)",
               name, $time, act, exp);
    end
  endtask

  // Expected control outputs for one cycle, straight from the per-state table.
  function automatic vec_t expect_vec(input phase_e p, input logic [6:0] op,
                                      input logic rdy, input logic z,
                                      input logic [2:0] f3, input logic [1:0] e);
    logic mreq, mwe, adr, irw, pcw, rw;
    logic [1:0] imm, a, b, aop, res;
    logic [3:0] st;
    {mreq, mwe, adr, irw, pcw, rw} = '0;
    {imm, a, b, aop, res} = '0;
    st = 4'(p);
    case (p)
      P_FETCH:    begin mreq = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; imm = 2'b10; end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; imm = (op == 7'b0100011) ? 2'b01 : 2'b00; end
      P_MEMREAD:  begin mreq = 1; adr = 1; end
      P_MEMWB:    begin rw = 1; res = 2'b01; end
      P_MEMWRITE: begin mreq = 1; mwe = 1; adr = 1; end
      P_EXEC_R:   begin a = 2'b10; aop = 2'b10; end
      P_EXEC_I:   begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      P_ALUWB:    rw = 1;
      P_BRANCH:   begin
        a = 2'b10; aop = 2'b01;
        pcw = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? !z : 1'b0);
      end
      default: ;
    endcase
    return {mreq, mwe, adr, irw, pcw, rw, imm, a, b, aop, res, e, st};
  endfunction

  task automatic model_reset();
    ph = P_FETCH;
    route.delete();
    waited = 0;
    m_err = 2'b00;
  endtask

  task automatic take(output phase_e n);
    if (route.size() != 0) n = route.pop_front();
    else n = P_FETCH;
  endtask

  task automatic model_step();
    phase_e nxt;
    nxt = ph;
    case (ph)
      P_FETCH, P_MEMREAD, P_MEMWRITE: begin
        if (mem_ready) begin
          if (ph == P_FETCH) nxt = P_DECODE;
          else take(nxt);
        end else begin
          waited++;
          if (LIMIT != 0 && waited >= LIMIT) begin
            nxt = P_HALT;
            m_err = 2'b10;
          end
        end
      end
      P_DECODE: begin
        route.delete();
        case (opcode)
          7'b0000011: begin route.push_back(P_MEMADR); route.push_back(P_MEMREAD); route.push_back(P_MEMWB); end
          7'b0100011: begin route.push_back(P_MEMADR); route.push_back(P_MEMWRITE); end
          7'b0110011: begin route.push_back(P_EXEC_R); route.push_back(P_ALUWB); end
          7'b0010011: begin route.push_back(P_EXEC_I); route.push_back(P_ALUWB); end
          7'b1100011: route.push_back(P_BRANCH);
          default: m_err = 2'b01;
        endcase
        if (m_err == 2'b01) nxt = P_HALT;
        else take(nxt);
      end
      P_HALT: nxt = P_HALT;
      default: take(nxt);
    endcase
    if (nxt != ph) waited = 0;
    ph = nxt;
  endtask

  task automatic pick_instr();
    int r;
    logic [6:0] bad_ops [4];
    bad_ops = '{7'b1111111, 7'b0110111, 7'b1101111, 7'b0000000};
    r = $urandom_range(0, 11);
    if (r < 2)       opcode = 7'b0000011;
    else if (r < 4)  opcode = 7'b0100011;
    else if (r < 6)  opcode = 7'b0110011;
    else if (r < 8)  opcode = 7'b0010011;
    else if (r < 11) opcode = 7'b1100011;
    else             opcode = bad_ops[$urandom_range(0, 3)];
    funct3 = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
  endtask

  // One active cycle: drive inputs, queue the expected response, advance the model.
  task automatic cycle_body();
    mem_ready = ($urandom_range(0, 99) < ready_pct);
    zero = 1'($urandom_range(0, 1));
    if (ph == P_FETCH) pick_instr();
    sb.push_back(expect_vec(ph, opcode, mem_ready, zero, funct3, m_err));
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", w_act, 22'd0);
    model_reset();
    halt_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle_body();
  endtask

  always @(negedge clk) begin : monitor
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ctl", w_act, e);
    end
  end

  initial begin
    phase_e cur;
    model_reset();
    ready_pct = 100;
    #1 check("reset", w_act, 22'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    opcode = 7'b0110011;
    cycle_body();
    for (int seg = 0; seg < 3; seg++) begin
      ready_pct = (seg == 0) ? 100 : ((seg == 1) ? 70 : 35);
      repeat (1000) begin
        @(posedge clk);
        #1;
        cur = ph;
        cycle_body();
        if (cur == P_HALT) halt_cnt++;
        else halt_cnt = 0;
        if (halt_cnt >= 20) begin
          do_reset();
        end else if (cur == P_MEMWRITE && (wr_resets == 0 || $urandom_range(0, 7) == 0)) begin
          wr_resets++;
          do_reset();
        end
      end
    end
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expected responses left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
